// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-way bus arbiter.
// Used by bus_arbiter_2x1; optional stats via ARB_STATS_EN.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam int   BUS_W = 8;

endpackage

// File: rtl/mux_2x1_8.sv
// 8-bit two-input bus multiplexer.
// SEL=0 passes A, SEL=1 passes B.
module mux_2x1_8 (
  output logic [7:0] Z,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       SEL
);

  assign Z = SEL ? B : A;

endmodule

// File: rtl/bus_arbiter_2x1.sv
// Round-robin 2:1 bus arbiter with hold limit and registered grants.
// Define ARB_STATS_EN to add saturating per-requester grant counters.
module bus_arbiter_2x1
  import bus_arb_pkg::*;
#(
  parameter int DATA_W   = BUS_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic [DATA_W-1:0] DATA_A,
  input  logic [DATA_W-1:0] DATA_B,
`ifdef ARB_STATS_EN
  input  logic              CNT_CLR,
  output logic [7:0]        CNT_A,
  output logic [7:0]        CNT_B,
`endif
  output logic              GNT_A,
  output logic              GNT_B,
  output logic              SEL,
  output logic [DATA_W-1:0] BUS_OUT,
  output logic              BUS_VALID
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t r_state;
  arb_state_t w_next;
  logic [7:0] r_hold;
  logic [7:0] w_hold;
  logic       r_last;
  logic       w_last;
  logic       r_sel;
  logic       w_sel;

  // r_last: 0 = A owned last, 1 = B owned last
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (REQ_A && REQ_B)
          w_next = r_last ? OWN_A : OWN_B;
        else if (REQ_A)
          w_next = OWN_A;
        else if (REQ_B)
          w_next = OWN_B;
      end
      OWN_A: begin
        if (!REQ_A)
          w_next = REQ_B ? OWN_B : IDLE;
        else if (REQ_B && r_hold == HOLD_LAST)
          w_next = OWN_B;
      end
      OWN_B: begin
        if (!REQ_B)
          w_next = REQ_A ? OWN_A : IDLE;
        else if (REQ_A && r_hold == HOLD_LAST)
          w_next = OWN_A;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_hold = r_hold;
    w_last = r_last;
    w_sel  = r_sel;
    if (w_next != r_state)
      w_hold = 8'd0;
    else if (r_hold != HOLD_LAST)
      w_hold = r_hold + 8'd1;
    if (r_state == OWN_A && w_next != OWN_A)
      w_last = 1'b0;
    if (r_state == OWN_B && w_next != OWN_B)
      w_last = 1'b1;
    if (w_next == OWN_A)
      w_sel = SEL_A;
    else if (w_next == OWN_B)
      w_sel = SEL_B;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_hold  <= 8'd0;
      r_last  <= 1'b1;
      r_sel   <= SEL_A;
    end else begin
      r_state <= w_next;
      r_hold  <= w_hold;
      r_last  <= w_last;
      r_sel   <= w_sel;
    end
  end

  assign GNT_A     = (r_state == OWN_A);
  assign GNT_B     = (r_state == OWN_B);
  assign SEL       = r_sel;
  assign BUS_VALID = GNT_A | GNT_B;

  mux_2x1_8 u_mux (
    .Z   (BUS_OUT),
    .A   (DATA_A),
    .B   (DATA_B),
    .SEL (r_sel)
  );

`ifdef ARB_STATS_EN
  logic [7:0] r_cnt_a;
  logic [7:0] r_cnt_b;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt_a <= 8'd0;
      r_cnt_b <= 8'd0;
    end else if (CNT_CLR) begin
      r_cnt_a <= 8'd0;
      r_cnt_b <= 8'd0;
    end else begin
      if (GNT_A && r_cnt_a != 8'hFF)
        r_cnt_a <= r_cnt_a + 8'd1;
      if (GNT_B && r_cnt_b != 8'hFF)
        r_cnt_b <= r_cnt_b + 8'd1;
    end
  end

  assign CNT_A = r_cnt_a;
  assign CNT_B = r_cnt_b;
`endif

  a_gnt_excl: assert property (
    @(posedge CLK) disable iff (!RST_N)
    !(GNT_A && GNT_B)
  );

endmodule

// File: tb/tb_bus_arbiter_2x1.sv
// Scoreboard bench for bus_arbiter_2x1 (MAX_HOLD=4).
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_bus_arbiter_2x1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       REQ_A = 1'b0;
  logic       REQ_B = 1'b0;
  logic [7:0] DATA_A = 8'h00;
  logic [7:0] DATA_B = 8'h00;
  logic       GNT_A;
  logic       GNT_B;
  logic       SEL;
  logic [7:0] BUS_OUT;
  logic       BUS_VALID;
`ifdef ARB_STATS_EN
  logic       CNT_CLR = 1'b0;
  logic [7:0] CNT_A;
  logic [7:0] CNT_B;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] e;

  always #5 CLK = ~CLK;

  bus_arbiter_2x1 #(.DATA_W(8), .MAX_HOLD(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .DATA_A    (DATA_A),
    .DATA_B    (DATA_B),
`ifdef ARB_STATS_EN
    .CNT_CLR   (CNT_CLR),
    .CNT_A     (CNT_A),
    .CNT_B     (CNT_B),
`endif
    .GNT_A     (GNT_A),
    .GNT_B     (GNT_B),
    .SEL       (SEL),
    .BUS_OUT   (BUS_OUT),
    .BUS_VALID (BUS_VALID)
  );

  wire [11:0] w_obs = {GNT_A, GNT_B, SEL, BUS_VALID, BUS_OUT};

  function automatic logic [11:0] ex(
    input logic ga, input logic gb,
    input logic s, input logic [7:0] bus);
    return {ga, gb, s, ga | gb, bus};
  endfunction

  task automatic do_reset();
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    DATA_A = 8'hA5;
    DATA_B = 8'h3C;
    RST_N = 1'b0;
    #2;
    n_vec++;
    if (w_obs !== ex(0, 0, 0, 8'hA5)) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h", w_obs, ex(0, 0, 0, 8'hA5));
    end
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    @(posedge CLK);
    #1;
    n_vec++;
    if (w_obs !== ex(0, 0, 0, 8'hA5)) begin
      n_err++;
      $display("FAIL reset_hold: got %h want %h", w_obs, ex(0, 0, 0, 8'hA5));
    end
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    RST_N = 1'b1;
  endtask

  task automatic test_single_a();
    do_reset();
    DATA_A = 8'h48;
    DATA_B = 8'h99;
    for (int k = 0; k < 5; k++) begin
      REQ_A = (k >= 1 && k <= 3);
      exp_q.push_back(REQ_A ? ex(1, 0, 0, 8'h48) : ex(0, 0, 0, 8'h48));
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL single_a[%0d]: got %h want %h", k, w_obs, e);
      end
    end
  endtask

  task automatic test_tie_rr();
    logic ob;
    do_reset();
    DATA_A = 8'h48;
    DATA_B = 8'h55;
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ob = ((k / 4) % 2) == 1;
      exp_q.push_back(ex(!ob, ob, ob, ob ? 8'h55 : 8'h48));
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL tie_rr[%0d]: got %h want %h", k, w_obs, e);
      end
    end
  endtask

  task automatic test_handover();
    do_reset();
    DATA_A = 8'h11;
    DATA_B = 8'h22;
    for (int k = 0; k < 6; k++) begin
      REQ_A = (k < 2);
      REQ_B = (k >= 2 && k < 4);
      if (k < 2)
        exp_q.push_back(ex(1, 0, 0, 8'h11));
      else if (k < 4)
        exp_q.push_back(ex(0, 1, 1, 8'h22));
      else
        exp_q.push_back(ex(0, 0, 1, 8'h22));
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL handover[%0d]: got %h want %h", k, w_obs, e);
      end
    end
  endtask

  task automatic test_b_hold();
    do_reset();
    DATA_A = 8'h0F;
    DATA_B = 8'hF0;
    REQ_B = 1'b1;
    for (int k = 0; k < 25; k++) begin
      REQ_A = (k >= 20);
      if (k < 20 || k == 24)
        exp_q.push_back(ex(0, 1, 1, 8'hF0));
      else
        exp_q.push_back(ex(1, 0, 0, 8'h0F));
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL b_hold[%0d]: got %h want %h", k, w_obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    DATA_A = 8'h66;
    DATA_B = 8'h77;
    for (int k = 0; k < 3; k++) begin
      REQ_A = (k == 0);
      REQ_B = (k != 0);
      exp_q.push_back(k == 0 ? ex(1, 0, 0, 8'h66) : ex(0, 1, 1, 8'h77));
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL reset_mid_pre[%0d]: got %h want %h", k, w_obs, e);
      end
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_vec++;
    if (w_obs !== ex(0, 0, 0, 8'h66)) begin
      n_err++;
      $display("FAIL reset_mid_async: got %h want %h", w_obs, ex(0, 0, 0, 8'h66));
    end
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    exp_q.push_back(ex(1, 0, 0, 8'h66));
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL reset_mid_tie: got %h want %h", w_obs, e);
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    REQ_A = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    n_vec++;
    if (CNT_A !== 8'd9 || CNT_B !== 8'd0) begin
      n_err++;
      $display("FAIL stats_count: got %0d/%0d want 9/0", CNT_A, CNT_B);
    end
    repeat (290) @(posedge CLK);
    #1;
    n_vec++;
    if (CNT_A !== 8'd255) begin
      n_err++;
      $display("FAIL stats_sat: got %0d want 255", CNT_A);
    end
    CNT_CLR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLR = 1'b0;
    n_vec++;
    if (CNT_A !== 8'd0) begin
      n_err++;
      $display("FAIL stats_clr: got %0d want 0", CNT_A);
    end
    @(posedge CLK);
    #1;
    n_vec++;
    if (CNT_A !== 8'd1) begin
      n_err++;
      $display("FAIL stats_after_clr: got %0d want 1", CNT_A);
    end
    REQ_A = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_tie_rr();
    test_handover();
    test_b_hold();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2x1.md
Name: bus_arbiter_2x1

Overview:
- Round-robin arbiter that shares the 8-bit internal bus between two requesters, A and B.
- Requester A is, for example, the ALU result; requester B is, for example, memory read data.
- It drives SEL of an internal mux_2x1_8 instance, producing the bus value and a valid flag.
- Grants are registered.
- A hold limit stops one requester from starving the other.

Parameters:
- DATA_W, 8, width of the data inputs and of BUS_OUT. Must match mux_2x1_8, so the value is fixed at 8.
- MAX_HOLD, 4, maximum number of consecutive grant cycles while the other side is requesting. Legal range is 1 to 255.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ_A  in  1  bus request from A. Level; held until done.
- REQ_B  in  1  bus request from B. Level; held until done.
- DATA_A  in  8  A's data.
- DATA_B  in  8  B's data.
- GNT_A  out  1  A owns the bus (registered).
- GNT_B  out  1  B owns the bus (registered).
- SEL  out  1  mux select: 0 selects A, 1 selects B (registered).
- BUS_OUT  out  8  SEL ? DATA_B : DATA_A (combinational through mux_2x1_8).
- BUS_VALID  out  1  GNT_A | GNT_B.

Behaviour:
- The design has one clock. Reset is asynchronous and active-low. Clock and reset ports are named CLK and RST_N.
- Values while RST_N=0:
  - state=IDLE, GNT_A=0, GNT_B=0, SEL=0, BUS_VALID=0.
  - LAST=1, so A wins the first tie.
  - HOLD_CNT=0.
  - BUS_OUT follows DATA_A.
- Internal state is an FSM with states IDLE, OWN_A and OWN_B. The state register is the source of GNT_A, GNT_B and SEL.
- Latency: REQ sampled at edge t gives GNT at t+1. REQ dropped before edge t gives GNT low after edge t, so a grant lasts exactly as many cycles as REQ is sampled high.
- Transitions from IDLE:
  - REQ_A & REQ_B: go to the side opposite LAST.
  - Only one REQ high: go to that side.
  - No REQ: stay in IDLE.
- Transitions from OWN_A (OWN_B mirrors it):
  - REQ_A=0: go to OWN_B if REQ_B, else IDLE. The A-to-B handover has no idle cycle.
  - REQ_A=1, REQ_B=1, HOLD_CNT==MAX_HOLD-1: preempt to OWN_B.
  - Otherwise stay in OWN_A.
- HOLD_CNT:
  - Set to 0 on every entry into OWN_A or OWN_B.
  - Increments each cycle the state is unchanged.
  - Saturates at MAX_HOLD-1, so an uncontested owner keeps the bus indefinitely.
- LAST is updated to the side that owned the bus whenever an OWN state is left.
- SEL keeps its last value in IDLE and is updated together with GNT.
- GNT_A & GNT_B is never 1; this is a required assertion.
- MAX_HOLD=1 with both requesting gives strict alternation every cycle.
- Reset mid-grant: all grants drop asynchronously. The first tie after release goes to A.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, the block adds two outputs, CNT_A[7:0] and CNT_B[7:0]:
  - Each counts cycles with GNT_x=1.
  - Each saturates at 255.
  - Both are cleared by RST_N and by an added input CNT_CLR, which is synchronous and has priority over increment.
- When undefined, these ports and logic do not exist. All other behaviour is identical.

Decomposition:
- Package bus_arb_pkg holds:
  - the typedef enum logic [1:0] arb_state_t {IDLE, OWN_A, OWN_B};
  - the constant SEL_A=1'b0 and SEL_B=1'b1;
  - the constant BUS_W=8.
- Sub-module: the existing mux_2x1_8, instantiated once with ports Z, A, B, SEL. No other sub-module.

Test Plan:
- Reset, then REQ_A=1 at cycle 2 with DATA_A=8'h48 → GNT_A=1, SEL=0, BUS_OUT=8'h48, BUS_VALID=1 from cycle 3. GNT_B stays 0.
- Both REQ rise in the same cycle after reset, DATA_B=8'h55 → A is granted first. With both held and MAX_HOLD=4, GNT_A lasts 4 cycles, then GNT_B, SEL=1 and BUS_OUT=8'h55 for 4 cycles, alternating thereafter.
- A owns the bus and drops REQ_A while REQ_B=1 → the next cycle gives GNT_B=1 with no IDLE cycle. Then drop REQ_B → IDLE, BUS_VALID=0, SEL stays 1.
- REQ_B alone held for 20 cycles → GNT_B stays 1 for all 20 cycles; the hold counter saturates and there is no preemption.
- RST_N pulsed low mid-OWN_B → GNT_B=0, SEL=0 immediately, without waiting for a clock. After release, a tie is granted to A.
- With ARB_STATS_EN defined:
  - After 300 A-grant cycles, CNT_A=255.
  - CNT_CLR=1 for one cycle gives CNT_A=0 on the next edge.
